// File: rtl/keccak_pkg.sv
// -----------------------------------------------------------------------------
// keccak_pkg
// Shared constants and types for the SHAKE pipeline.
//   - State, lane and rate widths for SHAKE128 / SHAKE256
//   - Operation mode encodings (SHAKE*_MODE_VEC)
//   - absorb_state_t: FSM states of absorb_stage
//   - rate_lanes(): number of rate lanes XORed for a given mode
// -----------------------------------------------------------------------------
package keccak_pkg;

    localparam int STATE_W        = 1600;
    localparam int LANE_W         = 64;
    localparam int NUM_LANES      = 25;
    localparam int RATE_SHAKE128  = 1344;
    localparam int RATE_SHAKE256  = 1088;
    localparam int LANES_SHAKE128 = 21;
    localparam int LANES_SHAKE256 = 17;

    localparam logic [1:0] SHAKE128_MODE_VEC = 2'b00;
    localparam logic [1:0] SHAKE256_MODE_VEC = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_PERM,
        NEXT,
        HANDOFF
    } absorb_state_t;

    // Any encoding other than SHAKE256 falls back to the wider SHAKE128 rate.
    function automatic int rate_lanes(input logic [1:0] mode);
        return (mode == SHAKE256_MODE_VEC) ? LANES_SHAKE256 : LANES_SHAKE128;
    endfunction

endpackage

// File: rtl/absorb_stage_if.sv
// -----------------------------------------------------------------------------
// absorb_stage_if
// Bundles the three links of absorb_stage:
//   rate_*     : padded rate blocks from load_datapath (valid/ready)
//   perm_*     : request/response to the permutation core
//   squeeze_*  : final state handoff to the squeeze stage (valid/ready)
// Modports:
//   slave  : absorb_stage view
//   master : environment view (upstream, permutation core, squeeze stage)
// -----------------------------------------------------------------------------
interface absorb_stage_if #(
    parameter int STATE_W = 1600,
    parameter int RATE_W  = 1344
) ();

    logic               rate_valid;
    logic               rate_ready;
    logic [RATE_W-1:0]  rate_input;
    logic               last_block;
    logic [1:0]         operation_mode;
    logic [31:0]        output_size;

    logic               perm_start;
    logic [STATE_W-1:0] perm_state_out;
    logic               perm_done;
    logic [STATE_W-1:0] perm_state_in;

    logic               squeeze_valid;
    logic               squeeze_ready;
    logic [STATE_W-1:0] squeeze_state;
    logic [31:0]        squeeze_output_size;
    logic [1:0]         squeeze_mode;

    modport slave (
        input  rate_valid, rate_input, last_block, operation_mode, output_size,
        input  perm_done, perm_state_in,
        input  squeeze_ready,
        output rate_ready,
        output perm_start, perm_state_out,
        output squeeze_valid, squeeze_state, squeeze_output_size, squeeze_mode
    );

    modport master (
        output rate_valid, rate_input, last_block, operation_mode, output_size,
        output perm_done, perm_state_in,
        output squeeze_ready,
        input  rate_ready,
        input  perm_start, perm_state_out,
        input  squeeze_valid, squeeze_state, squeeze_output_size, squeeze_mode
    );

endinterface

// File: rtl/rate_mask_xor.sv
// -----------------------------------------------------------------------------
// rate_mask_xor
// Combinational absorb step: XORs the mode-selected rate lanes of a padded
// block into the Keccak state. Capacity lanes and rate lanes beyond the
// mode's rate pass through unchanged, whatever the block carries there.
// Ports:
//   state_in  : current 1600-bit state
//   block     : padded rate block, lane i = block[LANE_W*i +: LANE_W]
//   mode      : operation mode selecting the rate mask
//   state_out : next state
// -----------------------------------------------------------------------------
module rate_mask_xor #(
    parameter int STATE_W = keccak_pkg::STATE_W,
    parameter int RATE_W  = keccak_pkg::RATE_SHAKE128,
    parameter int LANE_W  = keccak_pkg::LANE_W
) (
    input  logic [STATE_W-1:0] state_in,
    input  logic [RATE_W-1:0]  block,
    input  logic [1:0]         mode,
    output logic [STATE_W-1:0] state_out
);

    localparam int RATE_LANES  = RATE_W / LANE_W;
    localparam int TOTAL_LANES = STATE_W / LANE_W;

    int active_lanes;
    assign active_lanes = keccak_pkg::rate_lanes(mode);

    // NOTE: every lane is driven by a continuous assignment on every path, so
    // this block is pure combinational logic with no storage inferred.
    for (genvar i = 0; i < TOTAL_LANES; i++) begin : g_lane
        if (i < RATE_LANES) begin : g_rate
            assign state_out[i*LANE_W +: LANE_W] = (i < active_lanes)
                ? state_in[i*LANE_W +: LANE_W] ^ block[i*LANE_W +: LANE_W]
                : state_in[i*LANE_W +: LANE_W];
        end else begin : g_capacity
            assign state_out[i*LANE_W +: LANE_W] = state_in[i*LANE_W +: LANE_W];
        end
    end

endmodule

// File: rtl/absorb_stage.sv
// -----------------------------------------------------------------------------
// absorb_stage
// Absorb stage of the SHAKE pipeline. Accepts padded rate blocks, XORs each
// into the Keccak state, runs the permutation core once per block and, after
// the last block, hands the final state, output size and mode to squeeze.
// Ports:
//   clk          : clock
//   rst          : synchronous, active-low reset
//   block_count  : blocks absorbed in the current message (only when
//                  ABSORB_BLOCK_COUNT_EN is defined; saturates at 16'hFFFF)
//   bus (slave)  : rate_*, perm_* and squeeze_* links, see absorb_stage_if
// Optional feature macro: ABSORB_BLOCK_COUNT_EN
// -----------------------------------------------------------------------------
module absorb_stage #(
    parameter int STATE_W = keccak_pkg::STATE_W,
    parameter int RATE_W  = keccak_pkg::RATE_SHAKE128,
    parameter int LANE_W  = keccak_pkg::LANE_W
) (
    input  logic          clk,
    input  logic          rst,
`ifdef ABSORB_BLOCK_COUNT_EN
    output logic [15:0]   block_count,
`endif
    absorb_stage_if.slave bus
);

    keccak_pkg::absorb_state_t fsm_q;

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_xor;
    logic [STATE_W-1:0] xor_base;
    logic [1:0]         xor_mode;
    logic [1:0]         mode_q;
    logic [31:0]        size_q;
    logic               last_q;
    logic               rate_ready_q;
    logic               perm_start_q;
    logic               squeeze_valid_q;
    logic               accept;
`ifdef ABSORB_BLOCK_COUNT_EN
    logic [15:0]        count_q;
`endif

    assign accept = bus.rate_valid && rate_ready_q;

    // The first block of a message starts from zero and uses the incoming
    // mode, since nothing is latched yet; later blocks use the latched mode.
    assign xor_base = (fsm_q == keccak_pkg::IDLE) ? '0 : state_q;
    assign xor_mode = (fsm_q == keccak_pkg::IDLE) ? bus.operation_mode : mode_q;

    rate_mask_xor #(
        .STATE_W (STATE_W),
        .RATE_W  (RATE_W),
        .LANE_W  (LANE_W)
    ) u_rate_mask_xor (
        .state_in  (xor_base),
        .block     (bus.rate_input),
        .mode      (xor_mode),
        .state_out (state_xor)
    );

    // NOTE: the 1600-bit state is a plain register, not a memory, so it is
    // reset like any other flop; a reset must never expose a stale message.
    // NOTE: non-blocking assignments throughout, so every branch below reads
    // the values held before the edge regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fsm_q           <= keccak_pkg::IDLE;
            state_q         <= '0;
            mode_q          <= '0;
            size_q          <= '0;
            last_q          <= 1'b0;
            rate_ready_q    <= 1'b1;
            perm_start_q    <= 1'b0;
            squeeze_valid_q <= 1'b0;
`ifdef ABSORB_BLOCK_COUNT_EN
            count_q         <= '0;
`endif
        end else begin
            perm_start_q <= 1'b0;

            case (fsm_q)
                keccak_pkg::IDLE, keccak_pkg::NEXT: begin
                    if (accept) begin
                        state_q      <= state_xor;
                        last_q       <= bus.last_block;
                        rate_ready_q <= 1'b0;
                        perm_start_q <= 1'b1;
                        fsm_q        <= keccak_pkg::START;
                        if (fsm_q == keccak_pkg::IDLE) begin
                            mode_q <= bus.operation_mode;
                            size_q <= bus.output_size;
                        end
`ifdef ABSORB_BLOCK_COUNT_EN
                        if (count_q != 16'hFFFF) begin
                            count_q <= count_q + 16'd1;
                        end
`endif
                    end
                end

                keccak_pkg::START: begin
                    fsm_q <= keccak_pkg::WAIT_PERM;
                end

                keccak_pkg::WAIT_PERM: begin
                    if (bus.perm_done) begin
                        state_q <= bus.perm_state_in;
                        if (last_q) begin
                            squeeze_valid_q <= 1'b1;
                            fsm_q           <= keccak_pkg::HANDOFF;
                        end else begin
                            rate_ready_q <= 1'b1;
                            fsm_q        <= keccak_pkg::NEXT;
                        end
                    end
                end

                keccak_pkg::HANDOFF: begin
                    if (bus.squeeze_ready) begin
                        state_q         <= '0;
                        mode_q          <= '0;
                        size_q          <= '0;
                        last_q          <= 1'b0;
                        squeeze_valid_q <= 1'b0;
                        rate_ready_q    <= 1'b1;
                        fsm_q           <= keccak_pkg::IDLE;
`ifdef ABSORB_BLOCK_COUNT_EN
                        count_q         <= '0;
`endif
                    end
                end

                default: begin
                    fsm_q <= keccak_pkg::IDLE;
                end
            endcase
        end
    end

    assign bus.rate_ready          = rate_ready_q;
    assign bus.perm_start          = perm_start_q;
    assign bus.perm_state_out      = state_q;
    assign bus.squeeze_valid       = squeeze_valid_q;
    // Only the final state is offered downstream; intermediate states stay hidden.
    assign bus.squeeze_state       = squeeze_valid_q ? state_q : '0;
    assign bus.squeeze_output_size = size_q;
    assign bus.squeeze_mode        = mode_q;
`ifdef ABSORB_BLOCK_COUNT_EN
    assign block_count             = count_q;
`endif

endmodule

// File: tb/tb_absorb_stage.sv
// -----------------------------------------------------------------------------
// tb_absorb_stage
// Self-checking bench for absorb_stage: directed scenarios followed by
// randomized messages, all compared against a message-level reference model.
// Define ABSORB_BLOCK_COUNT_EN to also exercise block_count.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_absorb_stage;
    import keccak_pkg::*;

    localparam int SW = STATE_W;
    localparam int RW = RATE_SHAKE128;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    absorb_stage_if #(.STATE_W(SW), .RATE_W(RW)) bus ();

`ifdef ABSORB_BLOCK_COUNT_EN
    logic [15:0] block_count;
`endif

    absorb_stage #(
        .STATE_W (SW),
        .RATE_W  (RW),
        .LANE_W  (LANE_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef ABSORB_BLOCK_COUNT_EN
        .block_count (block_count),
`endif
        .bus         (bus)
    );

    int n_tests;
    int n_fail;

    // Reference model: message-level view of what the stage holds.
    logic [SW-1:0] m_state;
    logic [1:0]    m_mode;
    logic [31:0]   m_size;
    logic          m_last;
    logic          m_in_msg;
    int            m_count;

    task automatic check(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
        int lane;
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            lane = 0;
            for (int i = NUM_LANES - 1; i >= 0; i--) begin
                if (got[64*i +: 64] !== exp[64*i +: 64]) lane = i;
            end
            $display("FAIL %s: lane %0d got %h expected %h", tag, lane,
                     got[64*lane +: 64], exp[64*lane +: 64]);
        end
    endtask

    // Rate mask as a plain bit count: low 1088 or 1344 bits set.
    function automatic logic [SW-1:0] rate_mask(input logic [1:0] mode);
        logic [SW-1:0] m = '0;
        int bits = (mode == SHAKE256_MODE_VEC) ? RATE_SHAKE256 : RATE_SHAKE128;
        for (int b = 0; b < bits; b++) m[b] = 1'b1;
        return m;
    endfunction

    function automatic logic [SW-1:0] rand_wide();
        logic [SW-1:0] v;
        for (int i = 0; i < SW / 32; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_state  = '0;
        m_mode   = '0;
        m_size   = '0;
        m_last   = 1'b0;
        m_in_msg = 1'b0;
        m_count  = 0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rate_ready"},    SW'(bus.rate_ready), SW'(1'b1));
        check({tag, "_perm_start"},    SW'(bus.perm_start), '0);
        check({tag, "_squeeze_valid"}, SW'(bus.squeeze_valid), '0);
        check({tag, "_state"},         bus.perm_state_out, '0);
        check({tag, "_sq_state"},      bus.squeeze_state, '0);
        check({tag, "_sq_size"},       SW'(bus.squeeze_output_size), '0);
        check({tag, "_sq_mode"},       SW'(bus.squeeze_mode), '0);
`ifdef ABSORB_BLOCK_COUNT_EN
        check({tag, "_block_count"},   SW'(block_count), '0);
`endif
    endtask

    // Offers one block while the stage is ready; checks the absorbed state.
    task automatic send_block(input logic [RW-1:0] blk, input logic last,
                              input logic [1:0] mode, input logic [31:0] size);
        bus.rate_input     = blk;
        bus.last_block     = last;
        bus.operation_mode = mode;
        bus.output_size    = size;
        bus.rate_valid     = 1'b1;
        check("ready_before_accept", SW'(bus.rate_ready), SW'(1'b1));
        if (!m_in_msg) begin
            m_state  = '0;
            m_mode   = mode;
            m_size   = size;
            m_in_msg = 1'b1;
        end
        m_state = m_state ^ (SW'(blk) & rate_mask(m_mode));
        m_last  = last;
        if (m_count < 16'hFFFF) m_count++;
        step();
        bus.rate_valid     = 1'b0;
        bus.operation_mode = 2'($urandom);
        bus.output_size    = $urandom;
        check("perm_start_high", SW'(bus.perm_start), SW'(1'b1));
        check("absorbed_state",  bus.perm_state_out, m_state);
        check("ready_low_busy",  SW'(bus.rate_ready), '0);
    endtask

    // Returns new_state on perm_done lat cycles after the perm_start cycle.
    task automatic run_perm(input logic [SW-1:0] new_state, input int lat);
        step();
        check("perm_start_one_cycle", SW'(bus.perm_start), '0);
        for (int i = 1; i < lat; i++) step();
        bus.perm_state_in = new_state;
        bus.perm_done     = 1'b1;
        step();
        bus.perm_done     = 1'b0;
        bus.perm_state_in = rand_wide();
        m_state = new_state;
        check("permuted_state", bus.perm_state_out, m_state);
        if (m_last) begin
            check("squeeze_valid_up", SW'(bus.squeeze_valid), SW'(1'b1));
            check("ready_low_handoff", SW'(bus.rate_ready), '0);
            check("squeeze_state", bus.squeeze_state, m_state);
            check("squeeze_mode",  SW'(bus.squeeze_mode), SW'(m_mode));
            check("squeeze_size",  SW'(bus.squeeze_output_size), SW'(m_size));
`ifdef ABSORB_BLOCK_COUNT_EN
            check("block_count", SW'(block_count), SW'(16'(m_count)));
`endif
        end else begin
            check("ready_next", SW'(bus.rate_ready), SW'(1'b1));
            check("squeeze_valid_low", SW'(bus.squeeze_valid), '0);
        end
    endtask

    // Holds squeeze_ready low for stall cycles (optionally offering blocks),
    // then completes the handoff.
    task automatic handoff(input int stall, input logic offer_blocks);
        for (int i = 0; i < stall; i++) begin
            bus.rate_valid = offer_blocks;
            bus.rate_input = RW'(rand_wide());
            step();
            check("stall_ready_low",    SW'(bus.rate_ready), '0);
            check("stall_valid_high",   SW'(bus.squeeze_valid), SW'(1'b1));
            check("stall_state_stable", bus.squeeze_state, m_state);
            check("stall_mode_stable",  SW'(bus.squeeze_mode), SW'(m_mode));
            check("stall_size_stable",  SW'(bus.squeeze_output_size), SW'(m_size));
        end
        bus.rate_valid    = 1'b0;
        bus.squeeze_ready = 1'b1;
        step();
        bus.squeeze_ready = 1'b0;
        model_clear();
        check_idle_outputs("after_handoff");
    endtask

    // Optional stray perm_done while waiting for the next block.
    task automatic stray_perm_done();
        bus.perm_state_in = rand_wide();
        bus.perm_done     = 1'b1;
        step();
        bus.perm_done     = 1'b0;
        check("stray_done_ignored", bus.perm_state_out, m_state);
    endtask

    logic [RW-1:0] blk;
    logic [SW-1:0] exp_state;
    logic [SW-1:0] s1;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        model_clear();
        rst                = 1'b0;
        bus.rate_valid     = 1'b0;
        bus.rate_input     = '0;
        bus.last_block     = 1'b0;
        bus.operation_mode = '0;
        bus.output_size    = '0;
        bus.perm_done      = 1'b0;
        bus.perm_state_in  = '0;
        bus.squeeze_ready  = 1'b0;

        step();
        step();
        check_idle_outputs("reset");
        rst = 1'b1;
        step();

        // Single SHAKE128 block, lanes 1..21.
        for (int i = 0; i < LANES_SHAKE128; i++) blk[64*i +: 64] = 64'(i + 1);
        exp_state = '0;
        for (int i = 0; i < LANES_SHAKE128; i++) exp_state[64*i +: 64] = 64'(i + 1);
        send_block(blk, 1'b1, SHAKE128_MODE_VEC, 32'd256);
        check("t1_lanes", bus.perm_state_out, exp_state);
        run_perm({200{8'hA5}}, 3);
        check("t1_squeeze_a5", bus.squeeze_state, {200{8'hA5}});
        handoff(0, 1'b0);

        // SHAKE256 masking of an all-ones block.
        send_block('1, 1'b1, SHAKE256_MODE_VEC, 32'd512);
        check("t2_mask", bus.perm_state_out, SW'({RATE_SHAKE256{1'b1}}));
        run_perm(rand_wide(), 2);
        handoff(1, 1'b0);

        // Two-block message; mode input changes between blocks.
        s1  = rand_wide();
        blk = RW'(rand_wide());
        send_block(RW'(rand_wide()), 1'b0, SHAKE256_MODE_VEC, 32'd1000);
        run_perm(s1, 1);
        send_block(blk, 1'b1, SHAKE128_MODE_VEC, 32'd5);
        check("t3_second", bus.perm_state_out, s1 ^ (SW'(blk) & SW'({RATE_SHAKE256{1'b1}})));
        run_perm(rand_wide(), 4);
        check("t3_mode_kept", SW'(bus.squeeze_mode), SW'(SHAKE256_MODE_VEC));
        handoff(0, 1'b0);

        // Backpressure with blocks offered, then a fresh message from zero.
        send_block(RW'(rand_wide()), 1'b1, SHAKE128_MODE_VEC, 32'd77);
        run_perm(rand_wide(), 2);
        handoff(10, 1'b1);
        blk = RW'(rand_wide());
        send_block(blk, 1'b1, SHAKE256_MODE_VEC, 32'd9);
        check("t4_fresh", bus.perm_state_out, SW'(blk) & SW'({RATE_SHAKE256{1'b1}}));
        run_perm(rand_wide(), 1);
        handoff(0, 1'b0);

        // Reset while waiting on the permutation, then a late perm_done.
        send_block(RW'(rand_wide()), 1'b1, SHAKE128_MODE_VEC, 32'd64);
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        model_clear();
        check_idle_outputs("mid_reset");
        bus.perm_state_in = rand_wide();
        bus.perm_done     = 1'b1;
        step();
        bus.perm_done     = 1'b0;
        check_idle_outputs("late_done");

        // Randomized messages, including the unknown mode encodings.
        for (int msg = 0; msg < 25; msg++) begin
            int nblk;
            logic [1:0] mode;
            logic [31:0] size;
            nblk = $urandom_range(1, 3);
            mode = 2'($urandom_range(0, 3));
            size = $urandom;
            for (int b = 0; b < nblk; b++) begin
                send_block(RW'(rand_wide()), (b == nblk - 1), mode, size);
                run_perm(rand_wide(), $urandom_range(1, 5));
                if (b != nblk - 1 && $urandom_range(0, 1) == 1) stray_perm_done();
            end
            handoff($urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end

`ifdef ABSORB_BLOCK_COUNT_EN
        // Three-block message for the block counter.
        for (int b = 0; b < 3; b++) begin
            send_block(RW'(rand_wide()), (b == 2), SHAKE128_MODE_VEC, 32'd128);
            run_perm(rand_wide(), 2);
        end
        check("t7_count_three", SW'(block_count), SW'(16'd3));
        handoff(2, 1'b0);
        check("t7_count_cleared", SW'(block_count), '0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
